// File: rtl/mem_to_regfile_loader.sv
// mem_to_regfile_loader: multicycle burst copier from DataMemory into RegFile.
// Each word takes READ -> WAIT -> WRITE; a burst ends with a one-cycle DONE.
// Every output is a flop loaded from the next-state decode, so outputs follow
// the state register with no combinational path from any input.
module mem_to_regfile_loader #(
    parameter int unsigned ADDR_W = 7,
    parameter int unsigned DATA_W = 32,
    parameter int unsigned REG_W  = 5,
    parameter int unsigned CNT_W  = 6
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              start,
    input  logic [ADDR_W-1:0] base_addr,
    input  logic [REG_W-1:0]  dest_reg,
    input  logic [CNT_W-1:0]  count,
    output logic [ADDR_W-1:0] mem_address,
    output logic              mem_read,
    input  logic [DATA_W-1:0] mem_read_data,
    output logic              reg_write,
    output logic [REG_W-1:0]  write_reg,
    output logic [DATA_W-1:0] write_data,
    output logic              busy,
    output logic              done,
    output logic              err
);

    localparam int unsigned NUM_REGS = 1 << REG_W;

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_READ  = 3'd1,
        S_WAIT  = 3'd2,
        S_WRITE = 3'd3,
        S_DONE  = 3'd4
    } state_t;

    state_t              state_q, state_d;
    logic [ADDR_W-1:0]   addr_q, addr_d;
    logic [REG_W-1:0]    reg_q, reg_d;
    logic [CNT_W-1:0]    rem_q, rem_d;
    logic [DATA_W-1:0]   data_q, data_d;
    logic [ADDR_W-1:0]   mem_address_d;
    logic [REG_W-1:0]    write_reg_d;
    logic                mem_read_d;
    logic                reg_write_d;
    logic                busy_d;
    logic                done_d;
    logic                err_d;
    logic [CNT_W-1:0]    end_sum_c;

    assign write_data = data_q;

    // Next-state, datapath updates and next-cycle output values
    always_comb begin
        state_d       = state_q;
        addr_d        = addr_q;
        reg_d         = reg_q;
        rem_d         = rem_q;
        data_d        = data_q;
        mem_address_d = mem_address;
        write_reg_d   = write_reg;
        err_d         = 1'b0;
        end_sum_c     = CNT_W'(dest_reg) + count;

        case (state_q)
            S_IDLE: begin
                if (start) begin
                    if (count == '0) begin
                        state_d = S_DONE;
                    end else if (end_sum_c > CNT_W'(NUM_REGS)) begin
                        err_d = 1'b1;
                    end else begin
                        state_d       = S_READ;
                        addr_d        = base_addr;
                        reg_d         = dest_reg;
                        rem_d         = count;
                        mem_address_d = base_addr;
                    end
                end
            end
            S_READ: begin
                state_d = S_WAIT;
            end
            S_WAIT: begin
                data_d      = mem_read_data;
                write_reg_d = reg_q;
                state_d     = S_WRITE;
            end
            S_WRITE: begin
                addr_d = addr_q + ADDR_W'(1);
                reg_d  = reg_q + REG_W'(1);
                rem_d  = rem_q - CNT_W'(1);
                if (rem_q == CNT_W'(1)) begin
                    state_d = S_DONE;
                end else begin
                    state_d       = S_READ;
                    mem_address_d = addr_q + ADDR_W'(1);
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        mem_read_d  = (state_d == S_READ) || (state_d == S_WAIT);
        reg_write_d = (state_d == S_WRITE) && (write_reg_d != '0);
        busy_d      = (state_d == S_READ) || (state_d == S_WAIT) || (state_d == S_WRITE);
        done_d      = (state_d == S_DONE);
    end

    // State, datapath and output registers; reset abandons any burst
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q     <= S_IDLE;
            addr_q      <= '0;
            reg_q       <= '0;
            rem_q       <= '0;
            data_q      <= '0;
            mem_address <= '0;
            write_reg   <= '0;
            mem_read    <= 1'b0;
            reg_write   <= 1'b0;
            busy        <= 1'b0;
            done        <= 1'b0;
            err         <= 1'b0;
        end else begin
            state_q     <= state_d;
            addr_q      <= addr_d;
            reg_q       <= reg_d;
            rem_q       <= rem_d;
            data_q      <= data_d;
            mem_address <= mem_address_d;
            write_reg   <= write_reg_d;
            mem_read    <= mem_read_d;
            reg_write   <= reg_write_d;
            busy        <= busy_d;
            done        <= done_d;
            err         <= err_d;
        end
    end

endmodule

// File: tb/tb_mem_to_regfile_loader.sv
// Bench for mem_to_regfile_loader: directed vector table, reset-mid-burst
// sequence and random bursts, all checked against a word-by-word copy model.
module tb_mem_to_regfile_loader;

    localparam int unsigned ADDR_W = 7;
    localparam int unsigned DATA_W = 32;
    localparam int unsigned REG_W  = 5;
    localparam int unsigned CNT_W  = 6;
    localparam int          WAIT_LIMIT = 120;

    logic              clock = 1'b0;
    logic              reset;
    logic              start;
    logic [ADDR_W-1:0] base_addr;
    logic [REG_W-1:0]  dest_reg;
    logic [CNT_W-1:0]  count;
    logic [ADDR_W-1:0] mem_address;
    logic              mem_read;
    logic [DATA_W-1:0] mem_read_data;
    logic              reg_write;
    logic [REG_W-1:0]  write_reg;
    logic [DATA_W-1:0] write_data;
    logic              busy;
    logic              done;
    logic              err;

    mem_to_regfile_loader dut (
        .clock         (clock),
        .reset         (reset),
        .start         (start),
        .base_addr     (base_addr),
        .dest_reg      (dest_reg),
        .count         (count),
        .mem_address   (mem_address),
        .mem_read      (mem_read),
        .mem_read_data (mem_read_data),
        .reg_write     (reg_write),
        .write_reg     (write_reg),
        .write_data    (write_data),
        .busy          (busy),
        .done          (done),
        .err           (err)
    );

    always #5 clock = ~clock;

    // DataMemory with combinational read; RegFile as observed through the write port
    logic [DATA_W-1:0] mem    [128];
    logic [DATA_W-1:0] rf     [32];
    logic [DATA_W-1:0] exp_rf [32];
    assign mem_read_data = mem[mem_address];

    int total = 0;
    int bad   = 0;

    int n_wr, n_err, n_done, n_busy;
    int addr_log[$];
    logic rd_prev = 1'b0;

    // Observe the DUT every cycle away from the active edge
    always @(negedge clock) begin
        if (reg_write) begin
            rf[write_reg] = write_data;
            n_wr++;
        end
        if (mem_read && !rd_prev) addr_log.push_back(int'(mem_address));
        rd_prev = mem_read;
        if (err)  n_err++;
        if (done) n_done++;
        if (busy) n_busy++;
    end

    task automatic chk(input string name, input longint act, input longint exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    function automatic longint all_outs();
        return longint'({mem_address, mem_read, reg_write, write_reg, write_data, busy, done, err});
    endfunction

    task automatic clear_counters();
        n_wr = 0; n_err = 0; n_done = 0; n_busy = 0;
        addr_log.delete();
    endtask

    // One burst: model predicts, DUT runs, everything observable is compared
    task automatic run_burst(input string tag, input int base, input int dest, input int cnt,
                             input bit poke, output int lat, output int err_o, output int wr_o);
        int m_lat, m_err, m_wr, m_busy, m_done;
        int exp_addr[$];
        int addr_bad, rf_bad;
        bit accepted;

        accepted = (cnt != 0) && (dest + cnt <= 32);
        m_lat = 0; m_err = 0; m_wr = 0; m_busy = 0; m_done = 1;
        if (cnt == 0) begin
            m_lat = 1;
        end else if (!accepted) begin
            m_err = 1; m_done = 0;
        end else begin
            m_lat  = 3 * cnt + 1;
            m_busy = 3 * cnt;
            for (int i = 0; i < cnt; i++) begin
                int a, r;
                a = (base + i) % 128;
                r = dest + i;
                exp_addr.push_back(a);
                if (r != 0) begin
                    exp_rf[r] = mem[a];
                    m_wr++;
                end
            end
        end

        @(negedge clock); #1;
        clear_counters();
        base_addr = ADDR_W'(base);
        dest_reg  = REG_W'(dest);
        count     = CNT_W'(cnt);
        start     = 1'b1;
        @(negedge clock);
        start = 1'b0;
        lat = 1;
        while (!done && lat < WAIT_LIMIT) begin
            @(negedge clock);
            lat++;
            if (poke && accepted && lat == 2) begin
                base_addr = ADDR_W'($urandom_range(0, 127));
                dest_reg  = REG_W'(5);
                count     = CNT_W'(1);
                start     = 1'b1;
            end else begin
                start = 1'b0;
            end
        end
        start = 1'b0;
        if (!done) lat = 0;
        repeat (2) @(negedge clock);
        #1;

        addr_bad = (addr_log.size() != exp_addr.size()) ? 1 : 0;
        if (addr_bad == 0)
            foreach (exp_addr[i]) if (addr_log[i] != exp_addr[i]) addr_bad++;
        rf_bad = 0;
        for (int r = 0; r < 32; r++) if (rf[r] !== exp_rf[r]) rf_bad++;

        chk({tag, " done_latency"}, lat, m_lat);
        chk({tag, " err_pulses"}, n_err, m_err);
        chk({tag, " done_pulses"}, n_done, m_done);
        chk({tag, " reg_writes"}, n_wr, m_wr);
        chk({tag, " busy_cycles"}, n_busy, m_busy);
        chk({tag, " addr_seq_mismatches"}, addr_bad, 0);
        chk({tag, " regfile_mismatches"}, rf_bad, 0);
        err_o = n_err;
        wr_o  = n_wr;
    endtask

    typedef struct {
        int base;
        int dest;
        int cnt;
        int exp_lat;
        int exp_err;
        int exp_wr;
        int spot_reg;
        int spot_val;
    } vec_t;

    vec_t vt[8];

    initial begin
        int lat, e, w;

        vt[0] = '{base: 0,   dest: 31, cnt: 1,  exp_lat: 4,  exp_err: 0, exp_wr: 1,  spot_reg: 31, spot_val: 16};
        vt[1] = '{base: 4,   dest: 1,  cnt: 5,  exp_lat: 16, exp_err: 0, exp_wr: 5,  spot_reg: 5,  spot_val: 6};
        vt[2] = '{base: 10,  dest: 0,  cnt: 2,  exp_lat: 7,  exp_err: 0, exp_wr: 1,  spot_reg: 1,  spot_val: 7};
        vt[3] = '{base: 127, dest: 20, cnt: 2,  exp_lat: 7,  exp_err: 0, exp_wr: 2,  spot_reg: 21, spot_val: 4};
        vt[4] = '{base: 0,   dest: 30, cnt: 3,  exp_lat: 0,  exp_err: 1, exp_wr: 0,  spot_reg: 30, spot_val: 0};
        vt[5] = '{base: 0,   dest: 5,  cnt: 0,  exp_lat: 1,  exp_err: 0, exp_wr: 0,  spot_reg: 0,  spot_val: 0};
        vt[6] = '{base: 50,  dest: 0,  cnt: 32, exp_lat: 97, exp_err: 0, exp_wr: 31, spot_reg: 31, spot_val: -1};
        vt[7] = '{base: 9,   dest: 1,  cnt: 32, exp_lat: 0,  exp_err: 1, exp_wr: 0,  spot_reg: 0,  spot_val: 0};

        reset = 1'b1; start = 1'b0; base_addr = '0; dest_reg = '0; count = '0;
        for (int i = 0; i < 128; i++) mem[i] = $urandom();
        for (int r = 0; r < 32; r++) begin rf[r] = '0; exp_rf[r] = '0; end
        mem[0] = 16;
        mem[4] = 5; mem[5] = 2; mem[6] = 0; mem[7] = 5; mem[8] = 6;
        mem[10] = 9; mem[11] = 7;
        mem[127] = 3;
        mem[81] = 32'hffff_ffff;

        repeat (2) @(negedge clock);
        chk("reset_outputs", all_outs(), 0);
        reset = 1'b0;

        // Directed vector table
        for (int i = 0; i < 8; i++) begin
            if (i == 3) mem[0] = 4;
            run_burst($sformatf("vec%0d", i), vt[i].base, vt[i].dest, vt[i].cnt, 1'b0, lat, e, w);
            chk($sformatf("vec%0d table_latency", i), lat, vt[i].exp_lat);
            chk($sformatf("vec%0d table_err", i), e, vt[i].exp_err);
            chk($sformatf("vec%0d table_writes", i), w, vt[i].exp_wr);
            if (vt[i].spot_val >= 0) chk($sformatf("vec%0d spot_reg", i), rf[vt[i].spot_reg], vt[i].spot_val);
            else chk($sformatf("vec%0d spot_reg", i), rf[vt[i].spot_reg], 32'hffff_ffff);
            if (i == 2) chk("vec2 reg0_untouched", rf[0], 0);
            if (i == 3) chk("vec3 reg20", rf[20], 3);
        end

        // Reset during WAIT of word 2 of a 5-word burst
        for (int i = 40; i < 45; i++) mem[i] = $urandom();
        @(negedge clock); #1;
        clear_counters();
        base_addr = ADDR_W'(40); dest_reg = REG_W'(10); count = CNT_W'(5); start = 1'b1;
        @(negedge clock);
        start = 1'b0;
        repeat (4) @(negedge clock);
        #1;
        chk("midreset pre_addr", mem_address, 41);
        chk("midreset pre_mem_read", mem_read, 1);
        reset = 1'b1;
        #1;
        chk("midreset outputs_zero", all_outs(), 0);
        @(negedge clock);
        reset = 1'b0;
        repeat (8) @(negedge clock);
        #1;
        chk("midreset writes", n_wr, 1);
        chk("midreset word1", rf[10], mem[40]);
        chk("midreset word2_unwritten", rf[11], exp_rf[11]);
        exp_rf[10] = mem[40];
        run_burst("after_reset", 40, 10, 5, 1'b0, lat, e, w);

        // Start requests while busy must be ignored
        run_burst("busy_start", 60, 12, 3, 1'b1, lat, e, w);

        // Random bursts against the model
        for (int t = 0; t < 25; t++) begin
            int b, d, c;
            for (int i = 0; i < 128; i++) mem[i] = $urandom();
            b = $urandom_range(0, 127);
            d = $urandom_range(0, 31);
            c = ($urandom_range(0, 9) == 0) ? 0 : $urandom_range(1, 32);
            if ($urandom_range(0, 1) == 1 && d + c > 32) c = 32 - d;
            run_burst($sformatf("rand%0d", t), b, d, c, 1'($urandom_range(0, 1)), lat, e, w);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
